// File: rtl/inst_fetch_if.sv
// Fetch-to-decode handshake: one instruction slot offered over valid/ready.
// Fetch drives the slot (master); decode supplies ready (slave).
interface inst_fetch_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  modport master (output out_valid, output out_pc, output out_inst, input out_ready);
  modport slave  (input out_valid, input out_pc, input out_inst, output out_ready);
endinterface

// File: rtl/inst_fetch.sv
// MIPS fetch stage: PC register, async ROM addressing, one-entry output slot with redirect flush.
// Optional: define INST_FETCH_ALIGN_CHECK_EN to flag misaligned fetch PCs on fetch_adel.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ROM_AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  inst_fetch_if.master      dec,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       pc
`ifdef INST_FETCH_ALIGN_CHECK_EN
  ,
  output logic              fetch_adel
`endif
);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t slot_state;
  logic        accept;
  logic        slot_free;
  logic        capture;
  logic        cap_bad;

  assign dec.out_valid = (slot_state == SLOT_FULL);
  assign rom_addr      = pc[ROM_AW+1:2];
  assign accept        = dec.out_valid & dec.out_ready;
  assign slot_free     = ~dec.out_valid | dec.out_ready;

`ifdef INST_FETCH_ALIGN_CHECK_EN
  // A faulting fetch parks the stage until a redirect steers it elsewhere.
  assign cap_bad = (pc[1:0] != 2'b00);
  assign capture = fetch_en & slot_free & ~redirect & ~fetch_adel;
`else
  assign cap_bad = 1'b0;
  assign capture = fetch_en & slot_free & ~redirect;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= RESET_PC;
      slot_state   <= SLOT_EMPTY;
      dec.out_pc   <= 32'h0;
      dec.out_inst <= 32'h0;
      fetch_cnt    <= 32'h0;
    end else begin
      if (accept) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end

      if (redirect) begin
        // Slot is flushed even when decode takes it this cycle; out_pc/out_inst go stale.
        pc         <= redirect_pc;
        slot_state <= SLOT_EMPTY;
      end else if (capture) begin
        dec.out_pc   <= pc;
        dec.out_inst <= cap_bad ? 32'h0 : rom_inst;
        slot_state   <= SLOT_FULL;
        if (!cap_bad) begin
          pc <= pc + 32'd4;
        end
      end else if (accept) begin
        slot_state <= SLOT_EMPTY;
      end
    end
  end

`ifdef INST_FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_adel <= 1'b0;
    end else if (redirect) begin
      fetch_adel <= 1'b0;
    end else if (capture) begin
      fetch_adel <= cap_bad;
    end
  end
`endif

endmodule
